// File: rtl/uart_pkg.sv
// Shared types and constants for the host serial link UART.
// No logic; state encodings and sizing constants only.
// Imported by every UART module.
package uart_pkg;

  // Payload bits per frame (8N1).
  localparam int DATA_BITS = 8;

  // 100 MHz system clock / 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter: counts 0..lastVal and pulses tick on the terminal count.
// tick is combinational from the count register; count wraps to 0 on tick.
// No backpressure; clr holds the count at 0 and suppresses tick.
module baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] lastVal,
  output logic          tick
);

  logic [CW-1:0] count;

  assign tick = !clr && (count == lastVal);

  // Free-running period counter, cleared while the owning FSM is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || (count == lastVal)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 2-flop input synchronizer and mid-bit sampling.
// rxValid pulses for one cycle right after the stop-bit sample (~2+CPB/2+9*CPB cycles).
// No backpressure: each good byte is presented once; framing errors are dropped.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxIn,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  rx_state_t            state, stateNext;
  logic [1:0]           rxSync;
  logic                 rxS;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic [IW-1:0]        bitIdx, bitIdxNext;
  logic [DATA_BITS-1:0] dataNext;
  logic                 validNext;
  logic                 baudClr;
  logic [CW-1:0]        baudLast;
  logic                 baudTick;

  // Two-flop synchronizer; resets to the idle (mark) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxSync <= 2'b11;
    end else begin
      rxSync <= {rxSync[0], rxIn};
    end
  end

  assign rxS = rxSync[1];

  // A half-period in START lands on the middle of the start bit; the wrap there
  // re-aligns the counter so later full periods hit the middle of each bit.
  assign baudClr  = (state == RX_IDLE);
  assign baudLast = (state == RX_START) ? HALF_LAST : BIT_LAST;

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (CW)
  ) uBaud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baudClr),
    .lastVal (baudLast),
    .tick    (baudTick)
  );

  // State, shift register and registered byte/valid outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RX_IDLE;
      shiftReg <= '0;
      bitIdx   <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bitIdx   <= bitIdxNext;
      rxData   <= dataNext;
      rxValid  <= validNext;
    end
  end

  // Next-state: detect start, confirm it mid-bit, shift in data, check stop.
  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitIdxNext = bitIdx;
    dataNext   = rxData;
    validNext  = 1'b0;
    case (state)
      RX_IDLE: begin
        bitIdxNext = '0;
        if (!rxS) begin
          stateNext = RX_START;
        end
      end
      RX_START: begin
        if (baudTick) begin
          // Line back high at mid start bit: treat as a glitch.
          stateNext = rxS ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baudTick) begin
          shiftNext  = {rxS, shiftReg[DATA_BITS-1:1]};
          bitIdxNext = bitIdx + 1'b1;
          if (bitIdx == IDX_LAST) begin
            stateNext = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (baudTick) begin
          // Straight back to IDLE so a following start bit is not missed.
          if (rxS) begin
            dataNext  = shiftReg;
            validNext = 1'b1;
          end
          stateNext = RX_IDLE;
        end
      end
      default: begin
        stateNext = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit.
// Start bit appears the cycle after the accepting edge; frame is 10 bit periods.
// Strobes while busy are dropped, not queued; busy low means the next strobe is taken.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txStb,
  output logic                 tx,
  output logic                 txBusy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  tx_state_t            state, stateNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic [IW-1:0]        bitIdx, bitIdxNext;
  logic                 txReg, txNext;
  logic                 baudClr;
  logic                 baudTick;

  // Counter only runs while a frame is on the wire.
  assign baudClr = (state == TX_IDLE);

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (CW)
  ) uBaud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baudClr),
    .lastVal (BIT_LAST),
    .tick    (baudTick)
  );

  // State, shift register and registered line output; line idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= TX_IDLE;
      shiftReg <= '0;
      bitIdx   <= '0;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bitIdx   <= bitIdxNext;
      txReg    <= txNext;
    end
  end

  // Next-state and next line level; the line value is chosen one cycle ahead
  // so each bit lands exactly on the period boundary.
  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitIdxNext = bitIdx;
    txNext     = txReg;
    case (state)
      TX_IDLE: begin
        txNext = 1'b1;
        if (txStb) begin
          shiftNext  = txData;
          bitIdxNext = '0;
          txNext     = 1'b0;
          stateNext  = TX_START;
        end
      end
      TX_START: begin
        if (baudTick) begin
          txNext    = shiftReg[0];
          stateNext = TX_DATA;
        end
      end
      TX_DATA: begin
        if (baudTick) begin
          // Index wraps 7 -> 0 on the way out to STOP.
          bitIdxNext = bitIdx + 1'b1;
          if (bitIdx == IDX_LAST) begin
            txNext    = 1'b1;
            stateNext = TX_STOP;
          end else begin
            shiftNext = shiftReg >> 1;
            txNext    = shiftReg[1];
          end
        end
      end
      TX_STOP: begin
        if (baudTick) begin
          txNext    = 1'b1;
          stateNext = TX_IDLE;
        end
      end
      default: begin
        txNext    = 1'b1;
        stateNext = TX_IDLE;
      end
    endcase
  end

  assign tx     = txReg;
  assign txBusy = (state != TX_IDLE);

endmodule

// File: rtl/uart_top_blk.sv
// Full-duplex 8N1 UART for the host serial link; independent TX and RX paths.
// TX start bit one cycle after the accepted strobe; RX valid after the stop-bit sample.
// TX ignores strobes while o_tx_busy; RX has no backpressure (one-cycle valid).
module uart_top_blk
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_stb,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid
);

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) uTx (
    .clk    (clk),
    .rst    (rst),
    .txData (i_tx_data),
    .txStb  (i_tx_stb),
    .tx     (o_tx),
    .txBusy (o_tx_busy)
  );

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) uRx (
    .clk     (clk),
    .rst     (rst),
    .rxIn    (i_rx),
    .rxData  (o_rx_data),
    .rxValid (o_rx_valid)
  );

endmodule

// File: tb/tb_uart_top_blk.sv
// Bench for uart_top_blk with an 8-clock bit period.
// Checks TX framing/timing, RX decode, error rejection, loopback and reset abort.
// Received bytes are matched in order against a queue of expected bytes.
module tb_uart_top_blk;

  localparam int CPB = 8;

  logic       clk;
  logic       rst;
  logic       rxPin;
  logic       rxDrv;
  logic       loopEn;
  logic [7:0] txData;
  logic       txStb;
  logic       txPin;
  logic       txBusy;
  logic [7:0] rxData;
  logic       rxValid;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int rxPulses = 0;
  int lastValidCyc = -1000;
  int startCyc = 0;
  int p0;
  logic [7:0] expQ[$];
  logic [7:0] monExp;

  assign rxPin = loopEn ? txPin : rxDrv;

  uart_top_blk #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (rxPin),
    .i_tx_data  (txData),
    .i_tx_stb   (txStb),
    .o_tx       (txPin),
    .o_tx_busy  (txBusy),
    .o_rx_data  (rxData),
    .o_rx_valid (rxValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Receive monitor: every valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst === 1'b1 && rxValid === 1'b1) begin
      rxPulses++;
      lastValidCyc = cyc;
      if (expQ.size() == 0) begin
        chk("rx_spurious", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        chk("rx_data", {24'd0, rxData}, {24'd0, monExp});
      end
    end
  end

  // Call just after a negedge with the transmitter idle. Strobes d, then samples
  // the 80 cycles of the frame; optionally fires an extra strobe mid-frame.
  task automatic txFrame(input logic [7:0] d, input bit injectMid);
    logic [9:0] expFrm;
    logic [9:0] frm;
    int unstable;
    int busyCnt;
    int k;
    expFrm   = {1'b1, d, 1'b0};
    frm      = '0;
    unstable = 0;
    busyCnt  = 0;
    txData   = d;
    txStb    = 1'b1;
    @(posedge clk);
    #1;
    txStb  = 1'b0;
    txData = 8'h00;
    for (int j = 0; j < 10 * CPB; j++) begin
      @(negedge clk);
      k = j / CPB;
      if (j % CPB == 0) frm[k] = txPin;
      else if (txPin !== frm[k]) unstable++;
      if (txBusy === 1'b1) busyCnt++;
      if (injectMid && j == 20) begin
        txData = 8'h3C;
        txStb  = 1'b1;
      end
      if (injectMid && j == 21) begin
        txStb  = 1'b0;
        txData = 8'h00;
      end
    end
    chk("tx_frame", {22'd0, frm}, {22'd0, expFrm});
    chk("tx_bit_stable", unstable, 0);
    chk("tx_busy_cycles", busyCnt, 10 * CPB);
    @(negedge clk);
    chk("tx_idle_busy", {31'd0, txBusy}, 32'd0);
    chk("tx_idle_line", {31'd0, txPin}, 32'd1);
  endtask

  // Call just after a negedge; drives one frame on rxDrv, 8 cycles per bit.
  task automatic rxSend(input logic [7:0] d, input logic stopBit);
    logic [9:0] frm;
    frm = {stopBit, d, 1'b0};
    startCyc = cyc;
    for (int b = 0; b < 10; b++) begin
      rxDrv = frm[b];
      repeat (CPB) @(negedge clk);
    end
    rxDrv = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst    = 1'b0;
    rxDrv  = 1'b1;
    loopEn = 1'b0;
    txData = 8'h00;
    txStb  = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_tx", {31'd0, txPin}, 32'd1);
    chk("reset_busy", {31'd0, txBusy}, 32'd0);
    chk("reset_rx_valid", {31'd0, rxValid}, 32'd0);
    chk("reset_rx_data", {24'd0, rxData}, 32'd0);

    // TX byte with an ignored mid-frame strobe, then a back-to-back frame
    txFrame(8'hA5, 1'b1);
    txFrame(8'h3C, 1'b0);
    repeat (5) @(negedge clk);

    // RX good frame
    p0 = rxPulses;
    expQ.push_back(8'h5A);
    rxSend(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    chk("rx_pulse_cnt", rxPulses - p0, 1);
    chk("rx_latency_ok", {31'd0, ((lastValidCyc - startCyc) <= 79)}, 32'd1);
    chk("rx_hold", {24'd0, rxData}, 32'h5A);

    // RX glitch
    p0 = rxPulses;
    rxDrv = 1'b0;
    repeat (2) @(negedge clk);
    rxDrv = 1'b1;
    repeat (20) @(negedge clk);
    chk("rx_glitch_pulses", rxPulses - p0, 0);

    // RX framing error
    p0 = rxPulses;
    rxSend(8'h81, 1'b0);
    repeat (20) @(negedge clk);
    chk("rx_ferr_pulses", rxPulses - p0, 0);
    chk("rx_ferr_hold", {24'd0, rxData}, 32'h5A);

    // Loopback, three back-to-back frames
    loopEn = 1'b1;
    @(negedge clk);
    p0 = rxPulses;
    expQ.push_back(8'h00);
    expQ.push_back(8'hFF);
    expQ.push_back(8'h55);
    txFrame(8'h00, 1'b0);
    txFrame(8'hFF, 1'b0);
    txFrame(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    chk("loop_pulses", rxPulses - p0, 3);
    chk("loop_sb_empty", expQ.size(), 0);

    // Reset in the middle of a looped-back frame
    p0 = rxPulses;
    txData = 8'h00;
    txStb  = 1'b1;
    @(negedge clk);
    txStb = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_tx_low", {31'd0, txPin}, 32'd0);
    chk("pre_rst_busy", {31'd0, txBusy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_tx_high", {31'd0, txPin}, 32'd1);
    chk("rst_busy", {31'd0, txBusy}, 32'd0);
    chk("rst_rx_valid", {31'd0, rxValid}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_drop_pulses", rxPulses - p0, 0);
    chk("rst_rx_data", {24'd0, rxData}, 32'd0);
    chk("rst_sb_empty", expQ.size(), 0);
    chk("rst_idle_line", {31'd0, txPin}, 32'd1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
